alu_ex_unit: RTL and testbench
==============================

ALU_EX_UNIT -- requirements
Module: alu_ex_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL provide parameter MUL_EN, default 1; 1 enables the iterative multiply op, 0 removes it.
REQ-003 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL provide ports in_valid input 1 / in_ready output 1  operand handshake.
REQ-007 SHALL provide port alu_op  input  4  operation code.
REQ-008 SHALL provide ports src_a, src_b  input  XLEN  operands.
REQ-009 SHALL provide ports out_valid output 1 / out_ready input 1  result handshake.
REQ-010 SHALL provide port alu_result  output  XLEN  registered result.
REQ-011 SHALL provide port illegal_op  output  1  qualified by out_valid; result came from an unsupported code.
REQ-012 SHALL provide port busy  output  1  high while a multiply iterates.

Function
REQ-013 Op codes SHALL be: 0000 add, 0001 sub, 0010 lui (pass src_b), 0011 and, 0100 xor, 0101 or, 0110 sll, 0111 srl, 1000 sra, 1001 slt, 1010 sltu, 1011 mul.
REQ-014 add/sub SHALL wrap modulo 2^XLEN; no overflow flag.
REQ-015 Shifts SHALL use only src_b[log2(XLEN)-1:0] as shift amount; sra replicates src_a[XLEN-1].
REQ-016 slt (signed) / sltu (unsigned) SHALL produce 1 or 0 zero-extended to XLEN.
REQ-017 mul SHALL return low XLEN bits of src_a*src_b (sign-agnostic) via shift-add, one bit of src_b per cycle.
REQ-018 Codes 1100-1111, and 1011 when MUL_EN=0, SHALL complete in one cycle with alu_result=0, illegal_op=1.
REQ-019 FSM states SHALL be IDLE, MUL, DONE.
REQ-020 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-021 Transfer SHALL occur on edge where in_valid && in_ready; operands/op sampled only then.
REQ-022 Non-mul op: result registered on the transfer edge; out_valid=1 the following cycle (latency 1), state stays IDLE.
REQ-023 mul: IDLE->MUL on transfer; busy=1; after exactly XLEN iteration edges MUL->DONE with out_valid=1 (latency XLEN+1 from transfer to out_valid).
REQ-024 DONE->IDLE on out_valid && out_ready edge; new input accepted no earlier than the cycle after.
REQ-025 alu_result and illegal_op SHALL hold stable while out_valid && !out_ready.
REQ-026 out_valid SHALL clear on out_ready edge unless a new single-cycle op transfers on that same edge (back-to-back, 1 result/cycle).
REQ-027 flush SHALL on its edge clear out_valid, illegal_op, busy, abort any multiply, force IDLE; an in_valid on the same edge is dropped (flush wins).
REQ-028 in_valid with in_ready=0 SHALL have no effect; upstream must hold values.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, out_valid=0, illegal_op=0, busy=0, alu_result=0, regardless of clk.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 on the first cycle; reset mid-multiply discards the partial product.

Verification
REQ-031 XLEN=32: add 0xFFFFFFFF+1 -> alu_result=0x00000000, out_valid one cycle after transfer.
REQ-032 sra src_a=0x80000000, src_b=0x00000024 (amount 4) -> 0xF8000000; slt -1,1 -> 1; sltu -1,1 -> 0.
REQ-033 mul 0x00010001*0x00010001 -> 0x00020001, out_valid exactly 33 cycles after transfer, in_ready=0 throughout.
REQ-034 out_ready held 0 for 5 cycles after result -> alu_result/out_valid stable, in_ready=0; then 10 back-to-back adds with out_ready=1 -> 10 results on 10 consecutive cycles.
REQ-035 flush at iteration 7 of mul -> out_valid stays 0, busy=0 next cycle, next add accepted immediately; rst_n pulse mid-mul -> all outputs 0 asynchronously.
REQ-036 alu_op=1110 -> alu_result=0, illegal_op=1; MUL_EN=0 build with 1011 -> same.

Source files
------------

// File: rtl/alu_ex_unit.sv
// Single-issue integer ALU execute stage: one-cycle ops plus an optional
// iterative shift-add multiplier, with valid/ready handshakes on both sides.
module alu_ex_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            illegal_op,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LUI  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            ill_q, ill_d;
  logic            ov_q, ov_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [SW-1:0]   shamt;
  logic            is_mul;
  logic            fire;

  assign shamt    = src_b[SW-1:0];
  assign is_mul   = (MUL_EN != 0) && (alu_op == OP_MUL);
  assign in_ready = (state_q == S_IDLE) && (!ov_q || out_ready);
  assign fire     = in_valid && in_ready && !flush;

  assign out_valid  = ov_q;
  assign alu_result = res_q;
  assign illegal_op = ill_q;
  assign busy       = (state_q == S_MUL);

  // Single-cycle datapath; mul only lands here as an illegal code when disabled.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_LUI:  alu_res = src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $signed(src_a) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_MUL:  alu_ill = (MUL_EN == 0);
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    ill_d    = ill_q;
    ov_d     = ov_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (is_mul) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = src_a;
            mplier_d = src_b;
            cnt_d    = '0;
            ov_d     = 1'b0;
            ill_d    = 1'b0;
          end else begin
            res_d = alu_res;
            ill_d = alu_ill;
            ov_d  = 1'b1;
          end
        end else if (out_ready) begin
          ov_d = 1'b0;
        end
      end
      S_MUL: begin
        // XLEN shift-add steps, then one edge to publish the product.
        if (cnt_q == CW'(XLEN)) begin
          state_d = S_DONE;
          res_d   = acc_q;
          ill_d   = 1'b0;
          ov_d    = 1'b1;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          ov_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      ov_d    = 1'b0;
      ill_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      ill_q    <= 1'b0;
      ov_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      ill_q    <= ill_d;
      ov_q     <= ov_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_ex_unit.sv
// Directed bench for alu_ex_unit: XLEN=32 with multiplier, plus a MUL_EN=0 build.
module tb_alu_ex_unit;
  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] src_a, src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            illegal_op;
  logic            busy;

  logic            flush2, in_valid2, in_ready2, out_valid2, out_ready2, illegal2, busy2;
  logic [3:0]      alu_op2;
  logic [XLEN-1:0] src_a2, src_b2, result2;

  int checks = 0;
  int errors = 0;

  alu_ex_unit #(.XLEN(XLEN), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .illegal_op(illegal_op), .busy(busy)
  );

  alu_ex_unit #(.XLEN(XLEN), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .alu_op(alu_op2), .src_a(src_a2), .src_b(src_b2), .out_valid(out_valid2),
    .out_ready(out_ready2), .alu_result(result2), .illegal_op(illegal2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    in_valid2 = 1'b1;
    alu_op2   = op;
    src_a2    = a;
    src_b2    = b;
    cyc();
    in_valid2 = 1'b0;
  endtask

  initial begin
    int  lat;
    logic bad;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = 4'h0;
    src_a = '0; src_b = '0; out_ready = 1'b1;
    flush2 = 1'b0; in_valid2 = 1'b0; alu_op2 = 4'h0; src_a2 = '0; src_b2 = '0; out_ready2 = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_illegal", illegal_op, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // add wrap, latency 1
    send(4'b0000, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_valid", out_valid, 1);
    chk("add_wrap", alu_result, 32'h0);
    chk("add_illegal", illegal_op, 0);
    send(4'b1000, 32'h8000_0000, 32'h24);
    chk("sra", alu_result, 32'hF800_0000);
    send(4'b1001, 32'hFFFF_FFFF, 32'h1);
    chk("slt", alu_result, 32'h1);
    send(4'b1010, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", alu_result, 32'h0);
    send(4'b0001, 32'h5, 32'h7);
    chk("sub", alu_result, 32'hFFFF_FFFE);
    send(4'b0010, 32'h1234, 32'hABCD_E000);
    chk("lui", alu_result, 32'hABCD_E000);
    send(4'b0011, 32'hFF00, 32'h0FF0);
    chk("and", alu_result, 32'h0F00);
    send(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor", alu_result, 32'h0FF0_0FF0);
    send(4'b0101, 32'h0F, 32'hF0);
    chk("or", alu_result, 32'hFF);
    send(4'b0110, 32'h1, 32'h21);
    chk("sll_masked", alu_result, 32'h2);
    send(4'b0111, 32'h8000_0000, 32'h1F);
    chk("srl", alu_result, 32'h1);
    cyc();
    chk("drain_valid", out_valid, 0);

    // multiply latency
    send(4'b1011, 32'h0001_0001, 32'h0001_0001);
    chk("mul_busy", busy, 1);
    chk("mul_valid_low", out_valid, 0);
    lat = 0; bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (out_valid) begin lat = k; break; end
      if (in_ready) bad = 1'b1;
    end
    chk("mul_latency", lat, 33);
    chk("mul_in_ready_low", bad, 0);
    chk("mul_result", alu_result, 32'h0002_0001);
    chk("mul_done_busy", busy, 0);
    chk("mul_done_in_ready", in_ready, 0);
    cyc();
    chk("mul_consumed", out_valid, 0);
    send(4'b1011, 32'hFFFF_FFFF, 32'h3);
    repeat (33) cyc();
    chk("mul_neg_valid", out_valid, 1);
    chk("mul_neg", alu_result, 32'hFFFF_FFFD);
    cyc();

    // backpressure, then back-to-back
    out_ready = 1'b0;
    send(4'b0000, 32'h3, 32'h4);
    chk("stall_first", alu_result, 32'h7);
    in_valid = 1'b1; alu_op = 4'b0000; src_a = 32'd10; src_b = 32'd20;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (!out_valid || alu_result !== 32'h7 || in_ready) bad = 1'b1;
    end
    chk("stall_hold", bad, 0);
    out_ready = 1'b1;
    cyc();
    chk("stall_release", alu_result, 32'd30);
    chk("stall_release_valid", out_valid, 1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      src_a = i; src_b = 32'd100;
      cyc();
      if (!out_valid || alu_result !== 32'(i + 100)) bad = 1'b1;
    end
    chk("b2b_ten", bad, 0);
    in_valid = 1'b0;
    cyc();
    chk("b2b_drain", out_valid, 0);

    // flush mid-multiply, with a simultaneous input dropped
    send(4'b1011, 32'h7, 32'h9);
    repeat (6) cyc();
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    in_valid = 1'b1; alu_op = 4'b0000; src_a = 32'h1; src_b = 32'h1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (out_valid) bad = 1'b1;
    end
    chk("flush_no_result", bad, 0);
    send(4'b0000, 32'h2, 32'h2);
    chk("flush_next_add_valid", out_valid, 1);
    chk("flush_next_add", alu_result, 32'h4);
    cyc();

    // async reset mid-multiply
    send(4'b1011, 32'h5, 32'h6);
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_result", alu_result, 0);
    chk("arst_illegal", illegal_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("arst_in_ready", in_ready, 1);
    chk("arst_no_result", out_valid, 0);

    // illegal codes
    send(4'b1110, 32'h5, 32'h5);
    chk("ill_1110_valid", out_valid, 1);
    chk("ill_1110_flag", illegal_op, 1);
    chk("ill_1110_result", alu_result, 0);
    send(4'b0000, 32'h1, 32'h1);
    chk("ill_cleared", illegal_op, 0);
    send2(4'b1011, 32'h3, 32'h4);
    chk("nomul_valid", out_valid2, 1);
    chk("nomul_flag", illegal2, 1);
    chk("nomul_result", result2, 0);
    chk("nomul_busy", busy2, 0);
    send2(4'b0000, 32'h3, 32'h4);
    chk("nomul_add", result2, 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
